// File: rtl/knn_local_sp_streamer_if.sv
// Handshake and buffer-port bundle for the local search-point streamer.
// The slave side is the streamer itself; the master side drives jobs and owns the buffer.
interface knn_local_sp_streamer_if #(
    parameter int DataWidth    = 256,
    parameter int AddressWidth = 11
);
    logic                    start;
    logic [AddressWidth-1:0] base_addr;
    logic [AddressWidth:0]   count;
    logic                    busy;
    logic                    done;
    logic [AddressWidth-1:0] mem_address0;
    logic                    mem_ce0;
    logic                    mem_we0;
    logic [DataWidth-1:0]    mem_d0;
    logic [DataWidth-1:0]    mem_q0;
    logic [DataWidth-1:0]    out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;

    modport slave (
        input  start, base_addr, count, mem_q0, out_ready,
        output busy, done, mem_address0, mem_ce0, mem_we0, mem_d0,
        output out_data, out_valid, out_last
    );

    modport master (
        output start, base_addr, count, mem_q0, out_ready,
        input  busy, done, mem_address0, mem_ce0, mem_we0, mem_d0,
        input  out_data, out_valid, out_last
    );
endinterface

// File: rtl/knn_local_sp_streamer.sv
// Streams count words from the local search-point buffer, starting at base_addr,
// through a 2-entry skid FIFO onto a valid/ready output with a last-beat marker.
module knn_local_sp_streamer #(
    parameter int DataWidth    = 256,
    parameter int AddressWidth = 11,
    parameter int AddressRange = 2048
) (
    input logic                     clk,
    input logic                     reset,
    knn_local_sp_streamer_if.slave  io
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam logic [AddressWidth-1:0] LastAddr = AddressWidth'(AddressRange - 1);
    localparam logic [AddressWidth:0]   OneLeft  = (AddressWidth + 1)'(1);

    state_t                  state_q, state_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic [AddressWidth:0]   left_q, left_d;
    logic                    inflight_q, inflight_d;
    logic                    infl_last_q, infl_last_d;
    logic [DataWidth-1:0]    fdata_q [2];
    logic [DataWidth-1:0]    fdata_d [2];
    logic [1:0]              flast_q, flast_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic [1:0]              fcnt_q, fcnt_d;
    logic                    done_q, done_d;
    logic                    pop;
    logic                    issue;

    // A beat leaves when the head is valid and downstream takes it.
    assign pop   = (fcnt_q != 2'd0) && io.out_ready;
    // Reads are credit-limited so the FIFO plus the in-flight read never exceed two words.
    assign issue = (state_q == RUN) && (left_q != '0) &&
                   (((fcnt_q + {1'b0, inflight_q}) < 2'd2) || pop);

    assign io.busy         = (state_q != IDLE);
    assign io.done         = done_q;
    assign io.mem_ce0      = issue;
    assign io.mem_address0 = addr_q;
    assign io.mem_we0      = 1'b0;
    assign io.mem_d0       = '0;
    assign io.out_valid    = (fcnt_q != 2'd0);
    assign io.out_data     = fdata_q[rd_ptr_q];
    assign io.out_last     = (fcnt_q != 2'd0) && flast_q[rd_ptr_q];

    // Next-state: job control, address walk, read tracking and FIFO bookkeeping.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        left_d      = left_q;
        fdata_d     = fdata_q;
        flast_d     = flast_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        done_d      = 1'b0;
        inflight_d  = issue;
        infl_last_d = issue && (left_q == OneLeft);
        fcnt_d      = fcnt_q + {1'b0, inflight_q} - {1'b0, pop};

        if (issue) begin
            addr_d = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
            left_d = left_q - OneLeft;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (inflight_q) begin
            fdata_d[wr_ptr_q] = io.mem_q0;
            flast_d[wr_ptr_q] = infl_last_q;
            wr_ptr_d          = ~wr_ptr_q;
        end

        unique case (state_q)
            IDLE: begin
                if (io.start) begin
                    if (io.count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        addr_d  = io.base_addr;
                        left_d  = io.count;
                    end
                end
            end
            RUN: begin
                if (issue && (left_q == OneLeft)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && flast_q[rd_ptr_q]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any job and drops in-flight data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            left_q      <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            fdata_q[0]  <= '0;
            fdata_q[1]  <= '0;
            flast_q     <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            fcnt_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            left_q      <= left_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            fdata_q     <= fdata_d;
            flast_q     <= flast_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fcnt_q      <= fcnt_d;
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_knn_local_sp_streamer.sv
// Bench for knn_local_sp_streamer: job table plus reset and busy-start sequences,
// with a buffer model and queues of expected reads and beats.
module tb_knn_local_sp_streamer;
    localparam int DW = 256;
    localparam int AW = 11;
    localparam int AR = 2048;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   cnt;
        int            rmode;
        int            lat;
        bit            poke;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    knn_local_sp_streamer_if #(.DataWidth(DW), .AddressWidth(AW)) io ();

    knn_local_sp_streamer #(
        .DataWidth(DW),
        .AddressWidth(AW),
        .AddressRange(AR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io(io)
    );

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            beat_cnt = 0;
    int            first_beat = -1;
    int            last_beat = -1;
    int            issued = 0;
    int            popped = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] held_data;
    logic          held_last;
    beat_t         exp_q[$];
    logic [AW-1:0] rd_q[$];
    vec_t          vecs[7];

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        logic [DW-1:0] r;
        for (int j = 0; j < 8; j++) r[j*32 +: 32] = {a, 5'(j), 16'hC3A5};
        return r;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Buffer model: one-cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (io.mem_ce0) io.mem_q0 <= pat(io.mem_address0);
    end

    // Output/read monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            bit p;
            p = io.out_valid && io.out_ready;
            if (prev_stall) begin
                check("hold_valid", io.out_valid, 1'b1);
                check("hold_data", io.out_data, held_data);
                check("hold_last", io.out_last, held_last);
            end
            if (io.mem_ce0) begin
                check("we0", io.mem_we0, 1'b0);
                check("fifo_room", ((issued - popped) < 2) || p, 1'b1);
                if (rd_q.size() == 0) begin
                    check("spurious_read", io.mem_address0, 'x);
                end else begin
                    check("rd_addr", io.mem_address0, rd_q.pop_front());
                end
                issued++;
            end
            if (p) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat", io.out_data, 'x);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", io.out_data, e.data);
                    check("beat_last", io.out_last, e.last);
                end
                popped++;
                beat_cnt++;
                if (first_beat < 0) first_beat = cyc;
                last_beat = cyc;
            end
            prev_stall = io.out_valid && !io.out_ready;
            held_data  = io.out_data;
            held_last  = io.out_last;
        end
    end

    task automatic push_job(input logic [AW-1:0] b, input logic [AW:0] n);
        for (int i = 0; i < int'(n); i++) begin
            logic [AW-1:0] a;
            beat_t e;
            a = AW'((int'(b) + i) % AR);
            e.data = pat(a);
            e.last = (i == int'(n) - 1);
            rd_q.push_back(a);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_job(input logic [AW-1:0] b, input logic [AW:0] n, input int rmode,
                           input int exp_lat, input bit poke);
        int lat;
        int bound;
        int base_cyc;
        bit got_done;
        push_job(b, n);
        first_beat   = -1;
        last_beat    = -1;
        io.start     = 1'b1;
        io.base_addr = b;
        io.count     = n;
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        io.start = 1'b0;
        base_cyc = cyc;
        lat      = 1;
        got_done = 1'b0;
        bound    = 4 * int'(n) + 20;
        while (!got_done && lat <= bound) begin
            if (io.done) begin
                got_done = 1'b1;
            end else begin
                check("busy", io.busy, n != 0);
                if (poke && lat == 2) begin
                    io.start     = 1'b1;
                    io.base_addr = 11'd900;
                    io.count     = 12'd3;
                end else begin
                    io.start = 1'b0;
                end
                case (rmode)
                    0:       io.out_ready = 1'b1;
                    1:       io.out_ready = ~io.out_ready;
                    default: io.out_ready = ($urandom_range(0, 3) != 0);
                endcase
                @(posedge clk);
                #1;
                lat++;
            end
        end
        io.start = 1'b0;
        check("done_seen", got_done, 1'b1);
        if (exp_lat != 0) check("done_lat", lat, exp_lat);
        check("beats_left", exp_q.size(), 0);
        check("reads_left", rd_q.size(), 0);
        if (rmode == 0 && n != 0) begin
            check("first_beat", first_beat - base_cyc, 2);
            check("burst_len", last_beat - first_beat, int'(n) - 1);
        end
        check("busy_at_done", io.busy, 1'b0);
        @(posedge clk);
        #1;
        check("done_pulse", io.done, 1'b0);
        exp_q.delete();
        rd_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, io.busy, 1'b0);
        check({tag, "_done"}, io.done, 1'b0);
        check({tag, "_ce0"}, io.mem_ce0, 1'b0);
        check({tag, "_valid"}, io.out_valid, 1'b0);
        check({tag, "_last"}, io.out_last, 1'b0);
        check({tag, "_addr"}, io.mem_address0, '0);
        check({tag, "_data"}, io.out_data, '0);
    endtask

    initial begin
        vecs[0] = '{11'd0,    12'd4,    0, 7,    1'b0};
        vecs[1] = '{11'd2046, 12'd4,    0, 7,    1'b0};
        vecs[2] = '{11'd10,   12'd8,    1, 0,    1'b0};
        vecs[3] = '{11'd7,    12'd0,    0, 1,    1'b0};
        vecs[4] = '{11'd300,  12'd2048, 0, 2051, 1'b0};
        vecs[5] = '{11'd2047, 12'd3,    2, 0,    1'b0};
        vecs[6] = '{11'd50,   12'd6,    0, 9,    1'b1};

        reset        = 1'b1;
        io.start     = 1'b0;
        io.base_addr = '0;
        io.count     = '0;
        io.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            run_job(vecs[v].base, vecs[v].cnt, vecs[v].rmode, vecs[v].lat, vecs[v].poke);
        end

        push_job(11'd100, 12'd10);
        beat_cnt     = 0;
        io.start     = 1'b1;
        io.base_addr = 11'd100;
        io.count     = 12'd10;
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        io.start = 1'b0;
        for (int k = 0; k < 50 && beat_cnt < 3; k++) begin
            @(posedge clk);
            #1;
        end
        check("three_beats", beat_cnt, 3);
        reset = 1'b1;
        #1;
        check_zero("midrst");
        exp_q.delete();
        rd_q.delete();
        issued = 0;
        popped = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("rst_no_done", io.done, 1'b0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_done", io.done, 1'b0);
        run_job(11'd5, 12'd1, 0, 4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
